// File: rtl/vga_pkg.sv
// Shared VGA timing types, 640x480 defaults and the total-count helper
// used by both the horizontal and vertical timing generators.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } v_state_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;

    function automatic int unsigned vga_total(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vsync_gen.sv
// Vertical timing generator: advances a line counter on the terminal
// horizontal count and decodes blanking, sync and frame strobes.
module vsync_gen
    import vga_pkg::*;
#(
    parameter int unsigned FRAME_HEIGHT     = VGA_V_ACTIVE,
    parameter int unsigned FRONT_PORCH      = VGA_V_FRONT,
    parameter int unsigned VSYNC_WIDTH      = VGA_V_SYNC,
    parameter int unsigned BACK_PORCH       = VGA_V_BACK,
    parameter int unsigned H_TOTAL          = vga_total(VGA_H_ACTIVE, VGA_H_FRONT,
                                                         VGA_H_SYNC, VGA_H_BACK),
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned FRAME_CNT_W      = 8,
    localparam int unsigned V_TOTAL = vga_total(FRAME_HEIGHT, FRONT_PORCH,
                                                VSYNC_WIDTH, BACK_PORCH),
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [HW-1:0]          h_count,
    output logic [VW-1:0]          v_count,
    output logic                   v_blank,
    output logic                   vsync,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    if (FRAME_HEIGHT < 1 || FRONT_PORCH < 1 || VSYNC_WIDTH < 1 || BACK_PORCH < 1
        || H_TOTAL < 2) begin : g_param_check
        $error("vsync_gen: timing parameters must be >= 1 and H_TOTAL >= 2");
    end

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] LAST_ACTIVE = VW'(FRAME_HEIGHT - 1);
    localparam logic [VW-1:0] LAST_FRONT  = VW'(FRAME_HEIGHT + FRONT_PORCH - 1);
    localparam logic [VW-1:0] LAST_SYNC   = VW'(FRAME_HEIGHT + FRONT_PORCH + VSYNC_WIDTH - 1);
    localparam logic [VW-1:0] LAST_LINE   = VW'(V_TOTAL - 1);
    localparam logic          VSYNC_IDLE  = VSYNC_ACTIVE_LOW;

    v_state_t               state_q, state_d;
    logic [VW-1:0]          v_count_q, v_count_d;
    logic                   v_blank_q, v_blank_d;
    logic                   vsync_q, vsync_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   adv;
    logic                   wrap;

    // Out-of-range h_count never matches H_LAST, so it is silently ignored.
    always_comb begin
        adv           = (h_count == H_LAST);
        wrap          = 1'b0;
        state_d       = state_q;
        v_count_d     = v_count_q;
        if (adv) begin
            v_count_d = v_count_q + 1'b1;
            unique case (state_q)
                ACTIVE: if (v_count_q == LAST_ACTIVE) state_d = FRONT;
                FRONT:  if (v_count_q == LAST_FRONT)  state_d = SYNC;
                SYNC:   if (v_count_q == LAST_SYNC)   state_d = BACK;
                BACK: begin
                    if (v_count_q == LAST_LINE) begin
                        state_d   = ACTIVE;
                        v_count_d = '0;
                        wrap      = 1'b1;
                    end
                end
                default: state_d = ACTIVE;
            endcase
        end
        // Outputs decode the next state so they move on the same edge as v_count.
        v_blank_d     = (state_d != ACTIVE);
        vsync_d       = (state_d == SYNC) ? ~VSYNC_IDLE : VSYNC_IDLE;
        frame_start_d = wrap;
        frame_count_d = frame_count_q + FRAME_CNT_W'(wrap);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= ACTIVE;
            v_count_q     <= '0;
            v_blank_q     <= 1'b0;
            vsync_q       <= VSYNC_IDLE;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            v_count_q     <= v_count_d;
            v_blank_q     <= v_blank_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign v_count     = v_count_q;
    assign v_blank     = v_blank_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/vsync_gen.md
# vsync_gen

Vertical timing generator for the VGA pipeline, directly downstream of the horizontal timing generator (`hsync`). It consumes the horizontal pixel counter, advances a line counter once per horizontal line, and produces `v_blank`, `vsync`, `v_count`, a one-cycle `frame_start` strobe and a free-running frame counter. Together with `hsync` it completes the raster timing feeding the pixel/colour stage.

## Interface
- `FRAME_HEIGHT`, default 480: visible lines per frame.
- `FRONT_PORCH`, default 10: lines between visible area and sync.
- `VSYNC_WIDTH`, default 2: sync pulse length in lines.
- `BACK_PORCH`, default 33: lines between sync and next visible area.
- `H_TOTAL`, default 800: total pixel clocks per line. Must equal the upstream `hsync` total.
- `VSYNC_ACTIVE_LOW`, default 1: sync polarity. 1 drives `vsync` low during sync; 0 drives it high.
- `FRAME_CNT_W`, default 8: width of `frame_count`.
- Derived: `V_TOTAL = FRAME_HEIGHT+FRONT_PORCH+VSYNC_WIDTH+BACK_PORCH`, `HW = $clog2(H_TOTAL)`, `VW = $clog2(V_TOTAL)`.
- `clk_in`  in  1: pixel clock, shared with `hsync`.
- `reset`  in  1: asynchronous, active-high reset.
- `h_count`  in  HW: registered horizontal counter from `hsync`, 0..H_TOTAL-1.
- `v_count`  out  VW: current line, 0..V_TOTAL-1.
- `v_blank`  out  1: high on any line ≥ FRAME_HEIGHT.
- `vsync`  out  1: sync output, polarity set by `VSYNC_ACTIVE_LOW`.
- `frame_start`  out  1: one-cycle pulse when `v_count` wraps to 0.
- `frame_count`  out  FRAME_CNT_W: frames completed since reset, modulo 2^FRAME_CNT_W.

## Operation
- **Line advance:** `adv = (h_count == H_TOTAL-1)`. It is asserted for exactly one cycle per line when upstream is running.
- **h_count out of range:** any value ≥ H_TOTAL is never a terminal count. It is ignored and causes no advance or error.
- **FSM states:** ACTIVE, FRONT, SYNC, BACK. The state is registered alongside `v_count`.
- **Transitions, taken only on `adv`:**
  - ACTIVE→FRONT when `v_count == FRAME_HEIGHT-1`.
  - FRONT→SYNC at `FRAME_HEIGHT+FRONT_PORCH-1`.
  - SYNC→BACK at `FRAME_HEIGHT+FRONT_PORCH+VSYNC_WIDTH-1`.
  - BACK→ACTIVE at `V_TOTAL-1`.
- **v_count:** increments on `adv` and wraps V_TOTAL-1→0 on the same edge as BACK→ACTIVE. It holds otherwise, including when upstream stalls.
- **Frame wrap:** on the wrap edge, `frame_start` is 1 for the following cycle only and `frame_count` increments, wrapping 2^FRAME_CNT_W-1→0.
- **Output decoding:** `v_blank` and `vsync` are registered and decoded from the next state. They therefore change on the same edge as `v_count`, with no skew.
- **Parameter checks:** all four timing parameters must be ≥1, and `H_TOTAL` must be ≥2. Violations are an elaboration-time `$error`.
- **Reset values (asynchronous, any time, including mid-frame or mid-sync):**
  - `v_count` = 0, state = ACTIVE.
  - `v_blank` = 0.
  - `vsync` = inactive (1 if `VSYNC_ACTIVE_LOW`, else 0).
  - `frame_start` = 0, `frame_count` = 0.
- **No strobe out of reset:** there is no `frame_start` on reset release. The first pulse occurs at the first natural wrap.

## Timing
- `h_count` is assumed registered upstream. On the edge where `hsync` moves `h_count` from H_TOTAL-1 to 0, `vsync_gen` samples H_TOTAL-1 and updates `v_count`, `v_blank` and `vsync` on that same edge. Line boundaries therefore align exactly with `h_count == 0`.
- Latency from terminal `h_count` to updated outputs: one clock edge, with zero skew between the outputs.
- `frame_start` is high during the cycle where `v_count == 0` and `h_count == 0`.
- Each line state is held for exactly H_TOTAL cycles under continuous upstream operation.
- `vsync` is active for exactly `VSYNC_WIDTH*H_TOTAL` cycles per frame.

## Structure
- **Shared `vga_pkg`:**
  - `v_state_t` enum (ACTIVE, FRONT, SYNC, BACK), which `hsync` reuses for its horizontal FSM.
  - `localparam` VGA 640x480 defaults.
  - A `vga_total()` function for the H/V total computation.
- **No sub-module:** the counter and FSM live in one module. The boundary compares are localparams.

## Test plan
Bench parameters: FRAME_HEIGHT=4, FRONT_PORCH=1, VSYNC_WIDTH=2, BACK_PORCH=1 (V_TOTAL=8), H_TOTAL=14, with a real `hsync` upstream.
1. **Reset:** assert `reset` for 2 cycles. Expect `v_count`=0, `v_blank`=0, `vsync`=1, `frame_start`=0 and `frame_count`=0, checked asynchronously before any clock edge.
2. **Full frame sweep:** expect `v_count` to step 0..7, each value held 14 cycles. `v_blank`=1 exactly for lines 4..7, and `vsync`=0 exactly for lines 5..6 (28 cycles).
3. **Wrap:** over 3 frames, expect `frame_start` as a single-cycle pulse at each 7→0 transition and `frame_count` reading 1, 2, 3. With FRAME_CNT_W=2, the fourth wrap reads 0.
4. **Reset mid-sync:** pulse `reset` at `v_count`=5. Expect all outputs to return to reset values immediately, with no `frame_start`.
5. **Stall and out-of-range:** drive `h_count` directly, holding 3 for 50 cycles and then 15. Expect `v_count` unchanged throughout. Then drive 13 once and expect exactly one advance.
6. **Polarity:** with VSYNC_ACTIVE_LOW=0, expect `vsync`=0 out of reset and `vsync`=1 only on lines 5..6.
